// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle add/neg/sub/slt/and/or, plus an optional shift-add multiplier
// that is built only when the macro ULA_MULT_EN is defined.
module ula_multiciclo #(
  parameter int unsigned LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Inicio,
  input  logic [2:0]         ALUOp,
  input  logic [LARGURA-1:0] Entrada1,
  input  logic [LARGURA-1:0] Entrada2,
  output logic [LARGURA-1:0] Resultado,
  output logic               Zero,
  output logic               Negativo,
  output logic               Overflow,
  output logic               Pronto,
  output logic               Ocupado
);

  localparam int unsigned Msb = LARGURA - 1;

  logic [LARGURA-1:0] r_resultado;
  logic               r_zero;
  logic               r_negativo;
  logic               r_overflow;
  logic               r_pronto;

  logic [LARGURA-1:0] w_soma;
  logic [LARGURA-1:0] w_neg;
  logic [LARGURA-1:0] w_sub;
  logic [LARGURA-1:0] w_res;
  logic               w_ovf;
  logic               w_ocioso;
  logic               w_aceita_mul;

  assign w_soma = Entrada1 + Entrada2;
  assign w_neg  = '0 - Entrada1;
  assign w_sub  = Entrada1 - Entrada2;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUOp)
      3'b000: begin
        w_res = w_soma;
        w_ovf = (Entrada1[Msb] == Entrada2[Msb]) && (w_soma[Msb] != Entrada1[Msb]);
      end
      3'b001: begin
        w_res = w_neg;
        w_ovf = (Entrada1 == {1'b1, {(LARGURA - 1){1'b0}}});
      end
      3'b010: begin
        w_res = w_sub;
        w_ovf = (Entrada1[Msb] != Entrada2[Msb]) && (w_sub[Msb] != Entrada1[Msb]);
      end
      // Signed compare directly, so an overflowing E1-E2 cannot corrupt the answer
      3'b011:  w_res = {LARGURA{$signed(Entrada1) < $signed(Entrada2)}};
      3'b100:  w_res = Entrada1 & Entrada2;
      3'b101:  w_res = Entrada1 | Entrada2;
      default: w_res = '0;
    endcase
  end

`ifdef ULA_MULT_EN
  typedef enum logic {OCIOSO, MULTIPLICA} estado_t;

  localparam int unsigned LargPasso = $clog2(LARGURA) + 1;

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic [2*LARGURA-1:0]   r_multiplicando;
  logic [2*LARGURA-1:0]   r_acumulador;
  logic [2*LARGURA-1:0]   w_acum_prox;
  logic [LARGURA-1:0]     r_multiplicador;
  logic [LargPasso-1:0]   r_passo;
  logic                   w_ultimo;

  assign w_acum_prox  = r_multiplicador[0] ? (r_acumulador + r_multiplicando) : r_acumulador;
  assign w_ultimo     = (r_estado == MULTIPLICA) && (r_passo == LargPasso'(LARGURA - 1));
  assign w_ocioso     = (r_estado == OCIOSO);
  assign w_aceita_mul = w_ocioso && Inicio && (ALUOp == 3'b110);
  assign Ocupado      = (r_estado == MULTIPLICA);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:     if (w_aceita_mul) w_prox_estado = MULTIPLICA;
      MULTIPLICA: if (w_ultimo) w_prox_estado = OCIOSO;
      default:    w_prox_estado = OCIOSO;
    endcase
  end

  // One unsigned shift-add step per cycle while in MULTIPLICA
  always_ff @(posedge clock) begin
    if (reset) begin
      r_multiplicando <= '0;
      r_multiplicador <= '0;
      r_acumulador    <= '0;
      r_passo         <= '0;
    end else if (w_aceita_mul) begin
      r_multiplicando <= {{LARGURA{1'b0}}, Entrada1};
      r_multiplicador <= Entrada2;
      r_acumulador    <= '0;
      r_passo         <= '0;
    end else if (r_estado == MULTIPLICA) begin
      r_acumulador    <= w_acum_prox;
      r_multiplicando <= r_multiplicando << 1;
      r_multiplicador <= r_multiplicador >> 1;
      r_passo         <= r_passo + 1'b1;
    end
  end
`else
  assign w_ocioso     = 1'b1;
  assign w_aceita_mul = 1'b0;
  assign Ocupado      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_resultado <= '0;
      r_zero      <= 1'b1;
      r_negativo  <= 1'b0;
      r_overflow  <= 1'b0;
      r_pronto    <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (w_ocioso && Inicio && !w_aceita_mul) begin
        r_resultado <= w_res;
        r_zero      <= (w_res == '0);
        r_negativo  <= w_res[Msb];
        r_overflow  <= w_ovf;
        r_pronto    <= 1'b1;
      end
`ifdef ULA_MULT_EN
      else if (w_ultimo) begin
        r_resultado <= w_acum_prox[LARGURA-1:0];
        r_zero      <= (w_acum_prox[LARGURA-1:0] == '0);
        r_negativo  <= w_acum_prox[LARGURA-1];
        r_overflow  <= |w_acum_prox[2*LARGURA-1:LARGURA];
        r_pronto    <= 1'b1;
      end
`endif
    end
  end

  assign Resultado = r_resultado;
  assign Zero      = r_zero;
  assign Negativo  = r_negativo;
  assign Overflow  = r_overflow;
  assign Pronto    = r_pronto;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized bench for ula_multiciclo (LARGURA=8) against an integer-arithmetic reference model.
module tb_ula_multiciclo;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic         Inicio;
  logic [2:0]   ALUOp;
  logic [W-1:0] Entrada1;
  logic [W-1:0] Entrada2;
  logic [W-1:0] Resultado;
  logic         Zero;
  logic         Negativo;
  logic         Overflow;
  logic         Pronto;
  logic         Ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  ula_multiciclo #(.LARGURA(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .Inicio   (Inicio),
    .ALUOp    (ALUOp),
    .Entrada1 (Entrada1),
    .Entrada2 (Entrada2),
    .Resultado(Resultado),
    .Zero     (Zero),
    .Negativo (Negativo),
    .Overflow (Overflow),
    .Pronto   (Pronto),
    .Ocupado  (Ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef ULA_MULT_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  // Reference: plain signed/unsigned integer arithmetic on the operands
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic ov);
    int sa, sb, s;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd1: begin s = -sa;     r = W'(s); ov = (s > 127) || (s < -128); end
      3'd2: begin s = sa - sb; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd3: r = (sa < sb) ? 8'hFF : 8'h00;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: begin
        if (MulEn) begin
          p  = longint'(a) * longint'(b);
          r  = W'(p);
          ov = (p > 255);
        end
      end
      default: r = '0;
    endcase
  endtask

  task automatic chk_saida(input string tag, input logic [W-1:0] er, input logic eo);
    chk({tag, ".res"}, 32'(Resultado), 32'(er));
    chk({tag, ".zero"}, 32'(Zero), 32'(er == '0));
    chk({tag, ".neg"}, 32'(Negativo), 32'(er[W-1]));
    chk({tag, ".ovf"}, 32'(Overflow), 32'(eo));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".res"}, 32'(Resultado), 32'h0);
    chk({tag, ".zero"}, 32'(Zero), 32'h1);
    chk({tag, ".neg"}, 32'(Negativo), 32'h0);
    chk({tag, ".ovf"}, 32'(Overflow), 32'h0);
    chk({tag, ".pronto"}, 32'(Pronto), 32'h0);
    chk({tag, ".ocup"}, 32'(Ocupado), 32'h0);
  endtask

  // Called #1 after a rising edge; issues one op and checks its completion.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit idle, input bit injeta);
    logic [W-1:0] er;
    logic         eo;
    int           cnt;
    model(op, a, b, er, eo);
    Inicio   = 1'b1;
    ALUOp    = op;
    Entrada1 = a;
    Entrada2 = b;
    @(posedge clock);
    #1;
    Inicio   = 1'b0;
    ALUOp    = 3'($urandom);
    Entrada1 = W'($urandom);
    Entrada2 = W'($urandom);
    if (MulEn && op == 3'd6) begin
      cnt = 0;
      while (Ocupado === 1'b1 && cnt < 20) begin
        if (Pronto !== 1'b0) chk({tag, ".pronto_cedo"}, 32'(Pronto), 32'h0);
        Inicio = injeta && (cnt == 3);
        ALUOp  = 3'd0;
        @(posedge clock);
        #1;
        cnt++;
      end
      Inicio = 1'b0;
      chk({tag, ".ciclos_ocup"}, 32'(cnt), 32'(W));
    end
    chk({tag, ".pronto"}, 32'(Pronto), 32'h1);
    chk({tag, ".ocup"}, 32'(Ocupado), 32'h0);
    chk_saida(tag, er, eo);
    if (idle) begin
      @(posedge clock);
      #1;
      chk({tag, ".pronto_fim"}, 32'(Pronto), 32'h0);
      chk_saida({tag, ".hold"}, er, eo);
    end
  endtask

  initial begin
    reset    = 1'b1;
    Inicio   = 1'b1;
    ALUOp    = 3'd0;
    Entrada1 = 8'h7F;
    Entrada2 = 8'h01;
    repeat (2) @(posedge clock);
    #1;
    chk_reset("reset_com_inicio");
    reset  = 1'b0;
    Inicio = 1'b0;
    @(posedge clock);
    #1;
    chk_reset("pos_reset");

    do_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b1, 1'b0);
    do_op("neg_min", 3'd1, 8'h80, 8'h00, 1'b1, 1'b0);
    do_op("sub_zero", 3'd2, 8'h05, 8'h05, 1'b1, 1'b0);
    do_op("slt_true", 3'd3, 8'h80, 8'h01, 1'b0, 1'b0);
    do_op("slt_false", 3'd3, 8'h01, 8'h80, 1'b1, 1'b0);
    do_op("reservado", 3'd7, 8'h33, 8'h44, 1'b1, 1'b0);
    do_op("op110_a", 3'd6, 8'd3, 8'd4, 1'b1, 1'b0);
    do_op("op110_b", 3'd6, 8'd12, 8'd11, 1'b1, 1'b1);
    do_op("op110_c", 3'd6, 8'h10, 8'h10, 1'b0, 1'b0);
    do_op("back2back", 3'd5, 8'hA0, 8'h05, 1'b1, 1'b0);

    // Reset mid-operation must abort without a completion pulse
    do_op("pre_reset", 3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    Inicio   = 1'b1;
    ALUOp    = 3'd6;
    Entrada1 = 8'd12;
    Entrada2 = 8'd11;
    @(posedge clock);
    #1;
    Inicio = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_reset("reset_meio");
    reset = 1'b0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (Pronto !== 1'b0 || Ocupado !== 1'b0) chk("reset_sem_pronto", 32'(Pronto), 32'h0);
    end
    chk_reset("reset_estavel");

    for (int i = 0; i < 150; i++) begin
      do_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
